// File: rtl/ccp_frame_ctrl_pkg.sv
// Shared widths, frame geometry and FSM encoding for the CNN_Comp_Parallel frame sequencer.
package ccp_pkg;
  localparam int PIX_W       = 9;
  localparam int WT_W        = 2;
  localparam int RES_W       = 12;
  localparam int N_PIX       = 25;
  localparam int N_TAP       = 9;
  localparam int N_FILT      = 2;
  localparam int N_WT        = N_FILT * N_TAP;
  localparam int N_RES       = N_FILT * N_TAP;
  localparam int IDX_W       = 5;
  localparam int TIMEOUT_DEF = 64;

  // -2 is not a ternary weight; it is replaced by 0 and flagged.
  localparam logic [WT_W-1:0] WT_ILLEGAL = 2'b10;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_W   = 3'd1,
    LOAD_PIX = 3'd2,
    START    = 3'd3,
    WAIT     = 3'd4,
    DRAIN    = 3'd5
  } state_e;
endpackage

// File: rtl/ccp_frame_ctrl_if.sv
// Bundle of the input stream, datapath link, result stream and status flags.
interface ccp_frame_ctrl_if;
  import ccp_pkg::*;

  logic                           keep_wt;
  logic                           in_valid;
  logic                           in_ready;
  logic signed [PIX_W-1:0]        in_data;
  logic [N_PIX*PIX_W-1:0]         dp_pix;
  logic [N_WT*WT_W-1:0]           dp_wt;
  logic                           dp_start;
  logic                           dp_done;
  logic [N_RES*RES_W-1:0]         dp_res;
  logic                           out_valid;
  logic                           out_ready;
  logic signed [RES_W-1:0]        out_data;
  logic [IDX_W-1:0]               out_idx;
  logic                           out_last;
  logic                           busy;
  logic                           wt_loaded;
  logic                           err;

  modport master (
    input  keep_wt, in_valid, in_data, dp_done, dp_res, out_ready,
    output in_ready, dp_pix, dp_wt, dp_start, out_valid, out_data, out_idx,
           out_last, busy, wt_loaded, err
  );

  modport slave (
    output keep_wt, in_valid, in_data, dp_done, dp_res, out_ready,
    input  in_ready, dp_pix, dp_wt, dp_start, out_valid, out_data, out_idx,
           out_last, busy, wt_loaded, err
  );
endinterface

// File: rtl/ccp_res_drain.sv
// Captures the 18 datapath results on done and streams them out with valid/ready.
module ccp_res_drain
  import ccp_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    capture_i,
  input  logic [N_RES*RES_W-1:0]  res_i,
  input  logic                    out_ready_i,
  output logic                    out_valid_o,
  output logic signed [RES_W-1:0] out_data_o,
  output logic [IDX_W-1:0]        out_idx_o,
  output logic                    out_last_o,
  output logic                    done_o
);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_RES - 1);

  logic signed [RES_W-1:0] res_q [N_RES];
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    vld_q, vld_d;
  logic                    hs, at_last;

  assign hs      = vld_q && out_ready_i;
  assign at_last = (idx_q == IDX_LAST);

  always_comb begin
    idx_d = idx_q;
    vld_d = vld_q;
    if (capture_i) begin
      idx_d = '0;
      vld_d = 1'b1;
    end else if (hs) begin
      if (at_last) begin
        idx_d = '0;
        vld_d = 1'b0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      vld_q <= 1'b0;
      for (int i = 0; i < N_RES; i++) res_q[i] <= '0;
    end else begin
      idx_q <= idx_d;
      vld_q <= vld_d;
      if (capture_i) begin
        for (int i = 0; i < N_RES; i++) res_q[i] <= res_i[RES_W*i +: RES_W];
      end
    end
  end

  // Output fields come straight from registers, so they hold while stalled.
  assign out_valid_o = vld_q;
  assign out_data_o  = res_q[idx_q];
  assign out_idx_o   = idx_q;
  assign out_last_o  = vld_q && at_last;
  assign done_o      = hs && at_last;
endmodule

// File: rtl/ccp_frame_ctrl.sv
// Frame sequencer: loads weights/pixels from one stream, runs the datapath with a
// timeout, then drains the captured results.
module ccp_frame_ctrl
  import ccp_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input logic              clk,
  input logic              rst_n,
  ccp_frame_ctrl_if.master bus
);
  localparam int               TMO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [4:0]       WT_LAST  = 5'(N_WT - 1);
  localparam logic [4:0]       PIX_LAST = 5'(N_PIX - 1);

  state_e                  state_q, state_d;
  logic [4:0]              cnt_q, cnt_d;
  logic [TMO_W-1:0]        tmo_q, tmo_d;
  logic                    wt_loaded_q, wt_loaded_d;
  logic                    err_q, err_d;
  logic                    rdy, start, wt_we, pix_we, capture, drain_done;
  logic                    wt_bad;
  logic [WT_W-1:0]         wt_val;
  logic [WT_W-1:0]         wt_q  [N_WT];
  logic signed [PIX_W-1:0] pix_q [N_PIX];
  logic [N_WT*WT_W-1:0]    wt_flat;
  logic [N_PIX*PIX_W-1:0]  pix_flat;

  assign wt_bad = (bus.in_data[WT_W-1:0] == WT_ILLEGAL);
  assign wt_val = wt_bad ? '0 : bus.in_data[WT_W-1:0];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    wt_loaded_d = wt_loaded_q;
    err_d       = err_q;
    rdy         = 1'b0;
    start       = 1'b0;
    wt_we       = 1'b0;
    pix_we      = 1'b0;
    capture     = 1'b0;
    unique case (state_q)
      // The start beat only selects the path; it is consumed in the load state.
      IDLE: begin
        if (bus.in_valid) begin
          cnt_d = '0;
          if (bus.keep_wt && wt_loaded_q) begin
            state_d = LOAD_PIX;
          end else begin
            state_d     = LOAD_W;
            wt_loaded_d = 1'b0;
          end
        end
      end
      LOAD_W: begin
        rdy = 1'b1;
        if (bus.in_valid) begin
          wt_we = 1'b1;
          if (wt_bad) err_d = 1'b1;
          if (cnt_q == WT_LAST) begin
            wt_loaded_d = 1'b1;
            cnt_d       = '0;
            state_d     = LOAD_PIX;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      LOAD_PIX: begin
        rdy = 1'b1;
        if (bus.in_valid) begin
          pix_we = 1'b1;
          if (cnt_q == PIX_LAST) begin
            cnt_d   = '0;
            state_d = START;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      START: begin
        start   = 1'b1;
        tmo_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.dp_done) begin
          capture = 1'b1;
          state_d = DRAIN;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      DRAIN: begin
        if (drain_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      tmo_q       <= '0;
      wt_loaded_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      wt_loaded_q <= wt_loaded_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_WT; i++)  wt_q[i]  <= '0;
      for (int i = 0; i < N_PIX; i++) pix_q[i] <= '0;
    end else begin
      if (wt_we)  wt_q[cnt_q]  <= wt_val;
      if (pix_we) pix_q[cnt_q] <= bus.in_data;
    end
  end

  always_comb begin
    wt_flat  = '0;
    pix_flat = '0;
    for (int i = 0; i < N_WT; i++)  wt_flat[WT_W*i +: WT_W]    = wt_q[i];
    for (int i = 0; i < N_PIX; i++) pix_flat[PIX_W*i +: PIX_W] = pix_q[i];
  end

  ccp_res_drain u_drain (
    .clk        (clk),
    .rst_n      (rst_n),
    .capture_i  (capture),
    .res_i      (bus.dp_res),
    .out_ready_i(bus.out_ready),
    .out_valid_o(bus.out_valid),
    .out_data_o (bus.out_data),
    .out_idx_o  (bus.out_idx),
    .out_last_o (bus.out_last),
    .done_o     (drain_done)
  );

  assign bus.in_ready  = rdy;
  assign bus.dp_start  = start;
  assign bus.dp_wt     = wt_flat;
  assign bus.dp_pix    = pix_flat;
  assign bus.busy      = (state_q != IDLE);
  assign bus.wt_loaded = wt_loaded_q;
  assign bus.err       = err_q;
endmodule

// File: doc/ccp_frame_ctrl.md
Name: ccp_frame_ctrl

Overview:
- Frame sequencer for the CNN_Comp_Parallel datapath (5x5 signed image, two 3x3 ternary filters, 2x9 signed results).
- Accepts weights and pixels over one serial valid/ready stream and holds them as flat registers driving the datapath.
- Issues a start pulse, waits for done (with timeout), captures the 18 results, then streams them out over valid/ready.
- Sits between the input DMA/stream and the parallel datapath.

Parameters:
PIX_W, 9, pixel width (signed)
WT_W, 2, weight width (signed ternary: -1, 0, +1)
RES_W, 12, result width (signed)
N_PIX, 25, pixels per frame (5x5, row-major)
N_TAP, 9, taps per filter (3x3)
N_FILT, 2, filters
TIMEOUT, 64, maximum WAIT cycles before abort

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
keep_wt  in  1  reuse stored weights; sampled on frame start
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid&&in_ready
in_data  in  PIX_W  pixel, or weight in [WT_W-1:0] with upper bits ignored
dp_pix  out  N_PIX*PIX_W  pixel p at [PIX_W*p +: PIX_W]
dp_wt  out  N_FILT*N_TAP*WT_W  filter f tap t at [WT_W*(N_TAP*f+t) +: WT_W]
dp_start  out  1  one-cycle start pulse to datapath
dp_done  in  1  datapath results valid (pulse)
dp_res  in  N_FILT*N_TAP*RES_W  filter f output o at [RES_W*(N_TAP*f+o) +: RES_W]
out_valid  out  1  result beat valid
out_ready  in  1  downstream accept
out_data  out  RES_W  result value
out_idx  out  5  beat index 0..17 (= N_TAP*f+o)
out_last  out  1  high on beat 17
busy  out  1  state != IDLE
wt_loaded  out  1  complete weight set held
err  out  1  sticky: timeout or illegal weight; cleared only by reset

Behaviour:
- Reset: all outputs 0. Pixel, weight and result registers 0. State IDLE, counters 0.
- IDLE: in_ready=0. in_valid=1 starts a frame by sampling keep_wt.
  - If keep_wt && wt_loaded, next state is LOAD_PIX; otherwise LOAD_W.
  - One bubble cycle; the start beat is not consumed in IDLE.
- LOAD_W: in_ready=1. Entry clears wt_loaded. Each accepted beat writes dp_wt slot cnt (0..17); filter 0 taps first, then filter 1.
  - Weight 2'b10 (-2) is stored as 0 and sets err.
  - On beat 17: wt_loaded<=1, cnt<=0, next state LOAD_PIX.
- LOAD_PIX: in_ready=1. Beat cnt (0..24) writes dp_pix slot cnt. On beat 24: next state START.
- START: dp_start=1 for exactly one cycle. Next state WAIT; the timeout counter is cleared.
- WAIT: dp_pix and dp_wt stay stable.
  - dp_done=1: capture dp_res into result registers on the same edge, next state DRAIN.
  - Timeout counter reaches TIMEOUT-1 without dp_done: err<=1, return to IDLE, no output beats.
  - dp_done outside WAIT is ignored.
- DRAIN: out_valid=1, out_data = result[idx], out_last = (idx==17).
  - idx advances only on out_valid&&out_ready.
  - out_data, out_idx and out_last are held while out_ready=0.
  - After the beat-17 handshake: out_valid<=0, next state IDLE.
  - Latency: dp_done edge to first out_valid is 1 cycle.
- Back-to-back frames: IDLE re-entry followed by in_valid gives a 1-cycle bubble. Throughput for a weight-reuse frame is 25 + 2 + dp latency + 18 + 1 cycles minimum.
- Async reset mid-frame: immediate return to the reset state; partial data is discarded and wt_loaded=0.
- Arithmetic: no computation; results pass through unmodified (signed RES_W). Counters saturate at their terminal count and never wrap inside a state.

Decomposition:
- Shared package ccp_pkg: parameter defaults (PIX_W, WT_W, RES_W, N_PIX, N_TAP, N_FILT), the state encoding enum (IDLE, LOAD_W, LOAD_PIX, START, WAIT, DRAIN), and the illegal weight constant 2'b10.
- One sub-module: ccp_res_drain, holding the 18-entry result capture register plus the index/valid/ready output stage.
- The FSM, load counters and timeout stay in the top module.

Test Plan:
- Full frame, keep_wt=0: weights alternating +1/-1/0, pixels 1..25, dp_done 3 cycles after dp_start, model result_k=100+k, out_ready=1 -> dp_start pulses once after beat 43; 18 beats out_data 100..117, out_idx 0..17, out_last only on 117; busy falls the cycle after.
- Weight reuse: second frame with keep_wt=1 and 25 pixel beats -> no LOAD_W (in_ready high for exactly 25 accepted beats); dp_wt unchanged from frame 1; wt_loaded stays 1.
- Backpressure: out_ready toggled 1,0,0,1 repeatedly, in_valid gapped every other cycle -> no beat lost or duplicated; out_data stable while stalled; exactly 18 handshakes.
- Timeout: dp_done never asserted with TIMEOUT=64 -> err=1 exactly 64 cycles after WAIT entry; return to IDLE; out_valid never asserts; dp_done asserted later is ignored.
- Illegal weight: tap 4 of filter 1 = 2'b10 -> dp_wt slot 13 = 0 and err=1; the frame still completes normally.
- Reset mid-frame: rst_n low after 10 pixel beats -> all outputs 0 asynchronously and wt_loaded=0; the next frame with keep_wt=1 still goes through LOAD_W.
